// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one word-addressed read/write per handshake,
// committed after LATENCY cycles and answered through a held valid/ready response.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned Words = 2 ** DEPTH_LOG2;
    localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0]       mem_q [Words];

    logic              below_base;
    logic [31:0]       offset;
    logic [DEPTH_LOG2-1:0] idx;
    logic              acc_err;
    logic              commit;
    logic              mem_we;

    // Borrow of the 33-bit subtraction flags addr < BASE_ADDR without a wrapped offset.
    always_comb begin
        {below_base, offset} = {1'b0, addr_q} - {1'b0, BASE_ADDR};
        idx     = offset[DEPTH_LOG2+1:2];
        acc_err = (addr_q[1:0] != 2'b00) || below_base ||
                  ((offset >> (DEPTH_LOG2 + 2)) != 32'd0);
        commit  = (state_q == StWait) && (cnt_q == '0);
        mem_we  = commit && we_q && !acc_err && !rst_i;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    be_d    = req_be_i;
                    cnt_d   = CntInit;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    err_d   = acc_err;
                    rdata_d = (!acc_err && !we_q) ? mem_q[idx] : 32'h0;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is deliberately not reset; contents survive rst.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: a timing/memory model built from acceptance
// cycle numbers and a plain word array is compared against the DUT every cycle.
module tb_dmem_responder;

    localparam int unsigned L     = 2;
    localparam int unsigned DL2   = 10;
    localparam int unsigned WORDS = 2 ** DL2;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_be = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_LOG2 (DL2),
        .BASE_ADDR  (BASE),
        .LATENCY    (L)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: a transaction accepted at edge number acc answers from edge acc+L onward.
    bit          m_busy = 1'b0;
    int          m_cyc = 0;
    int          m_acc = 0;
    bit          m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_rdata = 32'h0;
    bit          m_err = 1'b0;
    bit          m_known_rsp = 1'b0;
    bit          m_after_rst = 1'b0;
    bit          m_started = 1'b0;
    logic [31:0] m_mem [WORDS];
    logic [3:0]  m_kmask [WORDS];

    function automatic bit m_valid();
        return m_busy && ((m_cyc - m_acc) >= int'(L));
    endfunction

    function automatic bit addr_err(input logic [31:0] a);
        longint d;
        d = longint'({32'h0, a}) - longint'({32'h0, BASE});
        if (a[1:0] != 2'b00) return 1'b1;
        if (d < 0) return 1'b1;
        return (d / 4) >= longint'(WORDS);
    endfunction

    task automatic m_commit();
        int idx;
        if (addr_err(m_addr)) begin
            m_err = 1'b1; m_rdata = 32'h0; m_known_rsp = 1'b1;
        end else begin
            idx = int'((m_addr - BASE) >> 2);
            m_err = 1'b0;
            if (m_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (m_be[i]) m_mem[idx][8*i +: 8] = m_wdata[8*i +: 8];
                end
                m_kmask[idx] = m_kmask[idx] | m_be;
                m_rdata = 32'h0; m_known_rsp = 1'b1;
            end else begin
                m_rdata = m_mem[idx];
                m_known_rsp = (m_kmask[idx] == 4'hF);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < int'(WORDS); i++) begin
            m_mem[i] = 32'h0; m_kmask[i] = 4'h0;
        end
        forever begin
            bit pv;
            @(posedge clk);
            pv = m_valid();
            m_cyc++;
            m_after_rst = rst;
            if (rst) m_started = 1'b1;
            if (rst) begin
                m_busy = 1'b0;
            end else if (!m_busy) begin
                if (req_valid) begin
                    m_busy = 1'b1; m_acc = m_cyc;
                    m_we = req_we; m_addr = req_addr; m_wdata = req_wdata; m_be = req_be;
                end
            end else if (pv) begin
                if (rsp_ready) m_busy = 1'b0;
            end else if ((m_cyc - m_acc) == int'(L)) begin
                m_commit();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_started) begin
                check("req_ready", {31'h0, req_ready}, {31'h0, !m_busy});
                check("rsp_valid", {31'h0, rsp_valid}, {31'h0, m_valid()});
                if (m_valid()) begin
                    check("rsp_err", {31'h0, rsp_err}, {31'h0, m_err});
                    if (m_known_rsp) check("rsp_rdata", rsp_rdata, m_rdata);
                end else if (m_after_rst) begin
                    check("rst_rdata", rsp_rdata, 32'h0);
                    check("rst_err", {31'h0, rsp_err}, 32'h0);
                end
            end
        end
    end

    int          got_lat;
    logic [31:0] got_rdata;
    logic        got_err;

    task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int stall, input int rst_at);
        int  stall_left;
        bit  done;
        stall_left = stall;
        done = 1'b0;
        got_lat = -1; got_rdata = 32'hFFFF_FFFF; got_err = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        rsp_ready = 1'($urandom_range(0, 1));
        for (int j = 1; j <= 200; j++) begin
            @(negedge clk);
            rst = 1'b0;
            if (!m_busy) begin
                done = 1'b1;
                break;
            end
            if (rsp_valid) begin
                if (got_lat < 0) got_lat = j - 1;
                got_rdata = rsp_rdata; got_err = rsp_err;
            end
            // Junk requests while busy must never be accepted.
            req_valid = 1'($urandom_range(0, 1));
            req_we = 1'($urandom_range(0, 1)); req_addr = $urandom;
            req_wdata = $urandom; req_be = 4'($urandom_range(0, 15));
            if (m_valid() && stall_left > 0) begin
                rsp_ready = 1'b0; stall_left--;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
            if (j == rst_at) rst = 1'b1;
        end
        if (!done) begin
            failures++; checks++;
            $display("FAIL txn_timeout: transaction to %h did not complete in 200 cycles", addr);
        end
        req_valid = 1'b0; rsp_ready = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_ready", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 64; i++) txn(1'b1, BASE + 32'(4 * i), 32'hA500_0000 | 32'(i), 4'hF, 0, -1);

        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, -1);
        check("wr_lat", 32'(got_lat), 32'd2);
        check("wr_err", {31'h0, got_err}, 32'h0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, -1);
        check("rd_lat", 32'(got_lat), 32'd2);
        check("rd_beef", got_rdata, 32'hDEAD_BEEF);

        txn(1'b1, 32'h10, 32'h0000_AA00, 4'b0010, 0, -1);
        check("mdl_pin", m_mem[4], 32'hDEAD_AAEF);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, -1);
        check("rd_partial", got_rdata, 32'hDEAD_AAEF);

        txn(1'b0, 32'h13, 32'h0, 4'h0, 0, -1);
        check("misalign_err", {31'h0, got_err}, 32'h1);
        check("misalign_rdata", got_rdata, 32'h0);
        txn(1'b0, 32'h1000, 32'h0, 4'h0, 0, -1);
        check("range_err", {31'h0, got_err}, 32'h1);
        check("range_rdata", got_rdata, 32'h0);
        txn(1'b1, 32'h1000, 32'h1234_5678, 4'hF, 0, -1);
        check("range_wr_err", {31'h0, got_err}, 32'h1);
        txn(1'b0, 32'h0, 32'h0, 4'h0, 0, -1);
        check("no_alias", got_rdata, 32'hA500_0000);

        txn(1'b1, 32'h14, 32'hFFFF_FFFF, 4'h0, 0, -1);
        txn(1'b0, 32'h14, 32'h0, 4'h0, 0, -1);
        check("be_zero", got_rdata, 32'hA500_0005);

        txn(1'b0, 32'h10, 32'h0, 4'h0, 5, -1);
        check("stall_rdata", got_rdata, 32'hDEAD_AAEF);
        check("stall_lat", 32'(got_lat), 32'd2);

        txn(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 0, 1);
        check("rst_no_rsp", 32'(got_lat), 32'hFFFF_FFFF);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, -1);
        check("rst_dropped_wr", got_rdata, 32'hA500_0008);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int          sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       a = BASE + 32'(4 * $urandom_range(0, 63));
            else if (sel == 6) a = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
            else if (sel == 7) a = BASE + 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
            else if (sel == 8) a = 32'hFFFF_FFFC;
            else               a = BASE + 32'(4 * $urandom_range(64, WORDS - 1));
            txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)),
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, L + 2)) : -1);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
